mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Upstream master for the RAM access block: converts single CPU load/store requests into the RAM's Enable/MOC handshake.
- Breaks a doubleword access into two sequential word beats.
- Sign- or zero-extends load results to 64 bits.
- Returns one done pulse per request, so the datapath never drives the RAM handshake directly.

Parameters:
- ADDR_W, 9, RAM byte-address width.
- MOC_TIMEOUT, 255, max cycles to wait for each MOC edge before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  request strobe, sampled only in IDLE
- req_rw  in  1  1 = read (load), 0 = write (store); same polarity as RAM ReadWrite
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 doubleword
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends
- req_addr  in  ADDR_W  byte address
- req_wdata  in  64  store data; byte/half/word use the low bits
- busy  out  1  high from request accept until done
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: timeout (or misalignment, see feature)
- rdata  out  64  load result; valid with done, held until next accept
- ram_en  out  1  RAM Enable
- ram_rw  out  1  RAM ReadWrite
- ram_mode  out  4  RAM mode: 0 byte, 1 half, 2 word
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  32  RAM data in
- ram_moc  in  1  RAM memory-operation-complete
- ram_rdata  in  32  RAM data out

Behaviour:
- Reset (async, immediate): state IDLE; busy, done, err, ram_en = 0; ram_rw = 1; ram_mode = 0; ram_addr, ram_wdata, rdata = 0.
- Reset mid-transaction aborts with no done pulse. ram_en drops in the same instant.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, NEXT, FINISH.
- IDLE: when req=1, latch all req_* fields, set busy, go to ISSUE. A req while busy is ignored and not queued.
- ISSUE: drive ram_addr, ram_rw, ram_mode, ram_wdata; set ram_en=1; go to WAIT_HI.
- WAIT_HI: wait for ram_moc=1.
  - On a read, capture ram_rdata.
  - Clear ram_en; go to WAIT_LO.
- WAIT_LO: wait for ram_moc=0.
  - If this was beat 0 of a doubleword, go to NEXT.
  - Otherwise go to FINISH.
- NEXT: ram_addr = (addr+4) mod 2^ADDR_W (wraps, no error). Drive wdata[31:0]; go to ISSUE.
- Doubleword beat 0 uses addr and wdata[63:32]. A read places beat 0 data in rdata[63:32] and beat 1 data in rdata[31:0].
- FINISH: pulse done for one cycle; clear busy; go to IDLE. A new req may be accepted in the cycle after done.
- Extension:
  - Byte loads use ram_rdata[7:0], extended per req_signed.
  - Half loads use [15:0], extended per req_signed.
  - Word loads use [31:0], extended per req_signed.
  - Doubleword loads are never extended.
  - Stores leave rdata unchanged.
- Timeout (MOC_TIMEOUT>0): a per-state counter runs in WAIT_HI and WAIT_LO. On reaching MOC_TIMEOUT: clear ram_en, set err=1, go to FINISH, skip any remaining beat.
- MOC already high on entry to ISSUE (stale): the FSM still waits for the full high-then-low sequence. No beat completes without WAIT_LO observing moc=0.
- Latency, with a RAM that raises MOC 1 cycle after en rises and drops it 1 cycle after en falls:
  - Single beat: done 5 cycles after the accept edge.
  - Doubleword: done 9 cycles after the accept edge.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: in IDLE, an accepted request that is misaligned skips all RAM traffic. The block pulses done with err=1 two cycles after accept; ram_en never rises.
  - Misaligned means: half with addr[0]≠0, word with addr[1:0]≠0, doubleword with addr[2:0]≠0.
- Not defined: no alignment check; any address is issued as given, and err reflects timeout only.

Test Plan:
- Word load, addr 0, RAM word 0x8000_00F1, req_signed=1 -> one en pulse with mode=2, addr 0; done at +5 cycles; rdata=0xFFFF_FFFF_8000_00F1; err=0.
- Byte load, addr 3, RAM byte 0x9C: signed -> rdata=0xFFFF_FFFF_FFFF_FF9C; unsigned -> rdata=0x0000_0000_0000_009C; mode=0 both times.
- Doubleword store, addr 4, wdata 0x00FF_FF00_FF00_00FF, then doubleword load, addr 4 -> en pulses at addresses 4 then 8; ram_wdata 0x00FF_FF00 then 0xFF00_00FF; load rdata equals the stored value; each done at +9.
- Doubleword at addr 508 -> second beat addr 0 (wrap); err=0.
- RAM model never raises MOC, MOC_TIMEOUT=8 -> ram_en falls; done with err=1 after 8 WAIT_HI cycles. Also: assert reset during WAIT_LO of beat 0 -> ram_en=0, busy=0, no done.
- MEM_ALIGN_CHECK_EN defined, word load at addr 2 -> done+err at +2, ram_en stays 0. Macro undefined, same request -> normal RAM access at addr 2.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - CPU load/store to RAM Enable/MOC handshake sequencer
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned half/word/doubleword requests finish with err, no RAM traffic.
module mem_access_sequencer #(
   parameter int ADDR_W      = 9,
   parameter int MOC_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              req_rw,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [63:0]       rdata,
   output logic              ram_en,
   output logic              ram_rw,
   output logic [3:0]        ram_mode,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic              ram_moc,
   input  logic [31:0]       ram_rdata
);

   localparam int CNT_W   = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT + 1) : 1;
   localparam int TO_LAST = (MOC_TIMEOUT > 0) ? MOC_TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] C_TO_LAST = TO_LAST[CNT_W-1:0];

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_NEXT, S_FINISH
   } state_t;

   state_t            r_state;
   logic              r_rw;
   logic [1:0]        r_size;
   logic              r_signed;
   logic [ADDR_W-1:0] r_addr;
   logic [63:0]       r_wdata;
   logic              r_beat;
   logic              r_fail;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [63:0]       r_rdata;
   logic              r_ram_en;
   logic              r_ram_rw;
   logic [3:0]        r_ram_mode;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [31:0]       r_ram_wdata;

   logic              w_dword;
   logic              w_timeout;
   logic [ADDR_W-1:0] w_addr_next;
   logic [63:0]       w_ext;

   assign w_dword     = (r_size == 2'b11);
   assign w_timeout   = (MOC_TIMEOUT != 0) && (r_cnt == C_TO_LAST);
   assign w_addr_next = r_addr + ADDR_W'(4);

   // Sign/zero extension of a single-beat load result
   always_comb begin
      w_ext = 64'd0;
      case (r_size)
         2'b00:   w_ext = {{56{r_signed & ram_rdata[7]}},  ram_rdata[7:0]};
         2'b01:   w_ext = {{48{r_signed & ram_rdata[15]}}, ram_rdata[15:0]};
         default: w_ext = {{32{r_signed & ram_rdata[31]}}, ram_rdata};
      endcase
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic w_misaligned;

   // Natural alignment check on the incoming request
   always_comb begin
      w_misaligned = 1'b0;
      case (req_size)
         2'b01:   w_misaligned = req_addr[0];
         2'b10:   w_misaligned = |req_addr[1:0];
         2'b11:   w_misaligned = |req_addr[2:0];
         default: w_misaligned = 1'b0;
      endcase
   end
`endif

   // Request sequencing FSM; every output is a register written here
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_rw        <= 1'b1;
         r_size      <= 2'b00;
         r_signed    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= 64'd0;
         r_beat      <= 1'b0;
         r_fail      <= 1'b0;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_rdata     <= 64'd0;
         r_ram_en    <= 1'b0;
         r_ram_rw    <= 1'b1;
         r_ram_mode  <= 4'd0;
         r_ram_addr  <= '0;
         r_ram_wdata <= 32'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_err <= 1'b0;
               if (req) begin
                  r_rw     <= req_rw;
                  r_size   <= req_size;
                  r_signed <= req_signed;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  r_beat   <= 1'b0;
                  r_busy   <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                  r_fail   <= w_misaligned;
                  r_state  <= w_misaligned ? S_FINISH : S_ISSUE;
`else
                  r_fail   <= 1'b0;
                  r_state  <= S_ISSUE;
`endif
               end
            end
            S_ISSUE: begin
               r_ram_en    <= 1'b1;
               r_ram_rw    <= r_rw;
               r_ram_mode  <= w_dword ? 4'd2 : {2'b00, r_size};
               r_ram_addr  <= r_beat ? w_addr_next : r_addr;
               r_ram_wdata <= (w_dword && !r_beat) ? r_wdata[63:32] : r_wdata[31:0];
               r_cnt       <= '0;
               r_state     <= S_WAIT_HI;
            end
            S_WAIT_HI: begin
               if (ram_moc) begin
                  if (r_rw) begin
                     if (!w_dword)    r_rdata         <= w_ext;
                     else if (!r_beat) r_rdata[63:32] <= ram_rdata;
                     else             r_rdata[31:0]   <= ram_rdata;
                  end
                  r_ram_en <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= S_WAIT_LO;
               end else if (w_timeout) begin
                  r_ram_en <= 1'b0;
                  r_fail   <= 1'b1;
                  r_state  <= S_FINISH;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_WAIT_LO: begin
               if (!ram_moc) begin
                  r_state <= (w_dword && !r_beat) ? S_NEXT : S_FINISH;
               end else if (w_timeout) begin
                  r_fail  <= 1'b1;
                  r_state <= S_FINISH;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_NEXT: begin
               r_beat      <= 1'b1;
               r_ram_addr  <= w_addr_next;
               r_ram_wdata <= r_wdata[31:0];
               r_state     <= S_ISSUE;
            end
            S_FINISH: begin
               r_done  <= 1'b1;
               r_err   <= r_fail;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign rdata     = r_rdata;
   assign ram_en    = r_ram_en;
   assign ram_rw    = r_ram_rw;
   assign ram_mode  = r_ram_mode;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - directed self-checking bench for mem_access_sequencer
module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        req_rw = 1'b1;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [8:0]  req_addr = 9'd0;
   logic [63:0] req_wdata = 64'd0;
   logic        busy, done, err;
   logic [63:0] rdata;
   logic        ram_en, ram_rw;
   logic [3:0]  ram_mode;
   logic [8:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_moc = 1'b0;
   logic [31:0] ram_rdata = 32'd0;

   int n_cmp = 0;
   int n_fail = 0;

   // RAM model controls and per-enable-pulse log
   logic        stall_hi = 1'b0;
   logic        stall_lo = 1'b0;
   logic        en_q = 1'b0;
   int          n_en = 0;
   logic [8:0]  log_addr [0:63];
   logic [31:0] log_wd   [0:63];
   logic [3:0]  log_mode [0:63];
   logic        log_rw   [0:63];
   logic [7:0]  mem      [0:511];

   mem_access_sequencer #(.ADDR_W(9), .MOC_TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata),
      .ram_en(ram_en), .ram_rw(ram_rw), .ram_mode(ram_mode), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_moc(ram_moc), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Big-endian byte RAM; MOC follows Enable half a cycle later
   always @(negedge clk) begin
      logic [8:0] a;
      a = ram_addr;
      if (ram_en && !en_q) begin
         log_addr[n_en & 63] = ram_addr;
         log_wd[n_en & 63]   = ram_wdata;
         log_mode[n_en & 63] = ram_mode;
         log_rw[n_en & 63]   = ram_rw;
         n_en = n_en + 1;
      end
      en_q = ram_en;
      if (ram_en && !ram_moc && !stall_hi) begin
         if (ram_rw) begin
            case (ram_mode)
               4'd0:    ram_rdata = {24'hA5A5A5, mem[a]};
               4'd1:    ram_rdata = {16'hA5A5, mem[a], mem[a + 9'd1]};
               default: ram_rdata = {mem[a], mem[a + 9'd1], mem[a + 9'd2], mem[a + 9'd3]};
            endcase
         end else begin
            case (ram_mode)
               4'd0: mem[a] = ram_wdata[7:0];
               4'd1: begin
                  mem[a] = ram_wdata[15:8]; mem[a + 9'd1] = ram_wdata[7:0];
               end
               default: begin
                  mem[a] = ram_wdata[31:24]; mem[a + 9'd1] = ram_wdata[23:16];
                  mem[a + 9'd2] = ram_wdata[15:8]; mem[a + 9'd3] = ram_wdata[7:0];
               end
            endcase
         end
         ram_moc = 1'b1;
      end else if (!ram_en && ram_moc && !stall_lo) begin
         ram_moc = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request; lat = clock cycle (1 = first cycle after the accept edge) in which done is high
   task automatic run_req(input logic rw, input logic [1:0] size, input logic sgn,
                          input logic [8:0] addr, input logic [63:0] wd,
                          output int lat, output logic e, output logic [63:0] rd,
                          output int base, output logic b_acc);
      @(posedge clk); #1;
      base = n_en;
      req = 1'b1; req_rw = rw; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req = 1'b0;
      b_acc = busy;
      lat = 0; e = 1'bx; rd = 'x;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k + 1; e = err; rd = rdata;
         end
      end
   endtask

   int          lat, base, seen;
   logic        e, b;
   logic [63:0] rd;

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done_err", {62'd0, done, err}, 64'd0);
      chk("rst_ram_en", {63'd0, ram_en}, 64'd0);
      chk("rst_ram_rw", {63'd0, ram_rw}, 64'd1);
      chk("rst_mode_addr", {51'd0, ram_mode, ram_addr}, 64'd0);
      chk("rst_wdata_rdata", {ram_wdata, 32'd0} | rdata, 64'd0);
      reset = 1'b0;

      // Word store then signed word load at 0
      run_req(1'b0, 2'b10, 1'b0, 9'd0, 64'h0000_0000_8000_00F1, lat, e, rd, base, b);
      chk("wst_busy_acc", {63'd0, b}, 64'd1);
      chk("wst_lat", lat, 5);
      chk("wst_pulses", n_en - base, 1);
      chk("wst_ram", {log_rw[base & 63], log_mode[base & 63], log_addr[base & 63], log_wd[base & 63]},
          {1'b0, 4'd2, 9'd0, 32'h8000_00F1});
      chk("wst_rdata_kept", rd, 64'd0);
      run_req(1'b1, 2'b10, 1'b1, 9'd0, 64'd0, lat, e, rd, base, b);
      chk("wld_lat", lat, 5);
      chk("wld_rdata", rd, 64'hFFFF_FFFF_8000_00F1);
      chk("wld_err", {63'd0, e}, 64'd0);
      chk("wld_busy_done", {63'd0, busy}, 64'd0);
      chk("wld_ram", {log_rw[base & 63], log_mode[base & 63], log_addr[base & 63]}, {1'b1, 4'd2, 9'd0});

      // Byte at 3: store 0x9C, signed and unsigned loads
      run_req(1'b0, 2'b00, 1'b0, 9'd3, 64'h9C, lat, e, rd, base, b);
      chk("bst_wdata", log_wd[base & 63], 32'h9C);
      run_req(1'b1, 2'b00, 1'b1, 9'd3, 64'd0, lat, e, rd, base, b);
      chk("bld_s_rdata", rd, 64'hFFFF_FFFF_FFFF_FF9C);
      chk("bld_s_mode", log_mode[base & 63], 4'd0);
      run_req(1'b1, 2'b00, 1'b0, 9'd3, 64'd0, lat, e, rd, base, b);
      chk("bld_u_rdata", rd, 64'h0000_0000_0000_009C);
      chk("bld_u_mode", log_mode[base & 63], 4'd0);

      // Halfword at 6
      run_req(1'b0, 2'b01, 1'b0, 9'd6, 64'h8001, lat, e, rd, base, b);
      run_req(1'b1, 2'b01, 1'b1, 9'd6, 64'd0, lat, e, rd, base, b);
      chk("hld_s_rdata", rd, 64'hFFFF_FFFF_FFFF_8001);
      chk("hld_mode", log_mode[base & 63], 4'd1);

`ifndef MEM_ALIGN_CHECK_EN
      // Doubleword at 4
      run_req(1'b0, 2'b11, 1'b0, 9'd4, 64'h00FF_FF00_FF00_00FF, lat, e, rd, base, b);
      chk("dst_lat", lat, 9);
      chk("dst_pulses", n_en - base, 2);
      chk("dst_beat0", {log_addr[base & 63], log_wd[base & 63]}, {9'd4, 32'h00FF_FF00});
      chk("dst_beat1", {log_addr[(base + 1) & 63], log_wd[(base + 1) & 63]}, {9'd8, 32'hFF00_00FF});
      chk("dst_rdata_kept", rd, 64'hFFFF_FFFF_FFFF_8001);
      run_req(1'b1, 2'b11, 1'b1, 9'd4, 64'd0, lat, e, rd, base, b);
      chk("dld_lat", lat, 9);
      chk("dld_rdata", rd, 64'h00FF_FF00_FF00_00FF);
      chk("dld_modes", {log_mode[base & 63], log_mode[(base + 1) & 63]}, {4'd2, 4'd2});

      // Doubleword at 508 wraps to 0
      run_req(1'b0, 2'b11, 1'b0, 9'd508, 64'hDEAD_BEEF_1234_5678, lat, e, rd, base, b);
      chk("dwrap_addrs", {log_addr[base & 63], log_addr[(base + 1) & 63]}, {9'd508, 9'd0});
      run_req(1'b1, 2'b11, 1'b0, 9'd508, 64'd0, lat, e, rd, base, b);
      chk("dwrap_rdata", rd, 64'hDEAD_BEEF_1234_5678);
      chk("dwrap_err", {63'd0, e}, 64'd0);

      // Misaligned word load goes to RAM unchanged
      run_req(1'b1, 2'b10, 1'b0, 9'd2, 64'd0, lat, e, rd, base, b);
      chk("mis_lat", lat, 5);
      chk("mis_addr", log_addr[base & 63], 9'd2);
      chk("mis_rdata", rd, 64'h0000_0000_5678_00FF);
`else
      // Misaligned word load rejected without RAM traffic
      run_req(1'b1, 2'b10, 1'b0, 9'd2, 64'd0, lat, e, rd, base, b);
      chk("mis_lat", lat, 2);
      chk("mis_err", {63'd0, e}, 64'd1);
      chk("mis_pulses", n_en - base, 0);
`endif

      // MOC never rises: timeout after 8 WAIT_HI cycles
      stall_hi = 1'b1;
      run_req(1'b1, 2'b10, 1'b0, 9'd0, 64'd0, lat, e, rd, base, b);
      chk("to_lat", lat, 11);
      chk("to_err", {63'd0, e}, 64'd1);
      chk("to_en_low", {63'd0, ram_en}, 64'd0);
      chk("to_pulses", n_en - base, 1);
      stall_hi = 1'b0;

      // Reset during WAIT_LO of beat 0
      stall_lo = 1'b1;
      @(posedge clk); #1;
      req = 1'b1; req_rw = 1'b1; req_size = 2'b11; req_addr = 9'd0;
      @(posedge clk); #1;
      req = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rmid_in_wait", {62'd0, busy, ram_moc}, 64'd3);
      reset = 1'b1;
      #1;
      chk("rmid_en", {63'd0, ram_en}, 64'd0);
      chk("rmid_busy", {63'd0, busy}, 64'd0);
      #1;
      reset = 1'b0;
      stall_lo = 1'b0;
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      chk("rmid_no_done", seen, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
